seq_bin2bcd: RTL
================

# seq_bin2bcd

Sequential binary-to-BCD converter that sits directly downstream of the 8x8 sequential multiplier. It samples the 16-bit product on a start strobe, converts it to five packed BCD digits by iterative shift-and-add-3 (double dabble), one bit per clock. It presents the result with a one-cycle done pulse for the display/readout stage. One conversion is in flight at a time.

## Interface
- WIDTH, 16, binary input width (matches multiplier product width)
- DIGITS, 5, number of BCD digits; 10^DIGITS must exceed 2^WIDTH-1
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request conversion of bin; sampled on rising clk edge
- bin  input  WIDTH  unsigned binary value (multiplier product C)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: bcd has just been updated
- bcd  output  4*DIGITS  packed BCD result; digit i at bits [4i+3:4i], digit 0 least significant

## Operation
- States: IDLE, SHIFT. No other states.
- Internal regs: bin_sh (WIDTH), scratch (4*DIGITS), cnt (ceil(log2(WIDTH+1)) bits).
- IDLE, start=1: bin_sh <= bin, scratch <= 0, cnt <= WIDTH, busy <= 1, go SHIFT.
- IDLE, start=0: hold; outputs unchanged except done, which returns to 0.
- SHIFT, each cycle:
  - adj = scratch with +3 applied to every digit whose value is >=5 (all digits evaluated in parallel, 4-bit add, no carry between digits).
  - {scratch, bin_sh} <= {adj, bin_sh} << 1.
  - cnt <= cnt - 1.
- SHIFT, cnt==1 (final step): bcd <= shifted adj result (same value scratch receives), done <= 1, busy <= 0, go IDLE.
- start while in SHIFT is ignored: not queued, bin not re-sampled.
- bin only sampled at the accepting edge; later changes on bin have no effect on the conversion.
- bcd holds its last result until the next conversion completes; it never shows intermediate values.
- All arithmetic unsigned; every digit of bcd is always 0..9.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, bcd=0, bin_sh=0, scratch=0, cnt=0. Takes effect immediately, without waiting for a clock edge.
- Reset mid-conversion: in-flight conversion discarded, bcd forced to 0, no done pulse. start is not accepted while rst_n=0.
- Start accepted at edge k: busy=1 after edge k.
- Shift steps occur at edges k+1 .. k+WIDTH.
- At edge k+WIDTH, bcd updates, done=1 and busy=0 for exactly one cycle. Latency is WIDTH (16) clocks from the accepting edge to done.
- Back-to-back: start may be high in the done cycle and is accepted at edge k+WIDTH+1. Maximum throughput is one conversion per WIDTH+1 clocks.
- start held high continuously: a new conversion is accepted at every IDLE edge (every WIDTH+1 clocks).
- done and busy are never high in the same cycle.

## Test plan
- Reset: rst_n=0 asserted asynchronously between edges -> busy=0, done=0, bcd=0x00000 immediately. Release and run 5 idle clocks -> outputs unchanged.
- Nominal: bin=8365 (239*35 from the multiplier), start pulsed 1 cycle -> busy high 16 cycles, then done pulse and bcd=0x08365. Change bin to 1234 after the start edge -> result still 0x08365.
- Boundaries: bin=0 -> bcd=0x00000. bin=65535 -> bcd=0x65535. bin=9 -> 0x00009. bin=10 -> 0x00010. Each completes with a single done pulse at 16 clocks.
- Start while busy: start bin=100, re-assert start with bin=200 at cycle 5 of SHIFT -> one done only, bcd=0x00100. busy never drops early.
- Back-to-back: start held high with bin=4095 then bin=512 at the done cycle -> bcd=0x04095, then 17 clocks later bcd=0x00512. Two done pulses 17 clocks apart.
- Reset mid-operation: start bin=8365, assert rst_n=0 at cycle 8 for 2 cycles, release -> no done pulse, bcd=0x00000. A new start bin=8365 then completes normally with bcd=0x08365.

Source files
------------

// File: rtl/seq_bin2bcd_if.sv
// ============================================================================
//  seq_bin2bcd_if : start/operand/result bundle between the multiplier and
//                   the sequential binary-to-BCD converter.
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface seq_bin2bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

`default_nettype wire

// File: rtl/seq_bin2bcd.sv
// ============================================================================
//  seq_bin2bcd : double-dabble binary-to-BCD converter, one bit per clock,
//                WIDTH clocks from accepted start to the done pulse.
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_bin2bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_bin2bcd_if.slave  bus
);

  localparam int              c_cnt_w    = $clog2(WIDTH + 1);
  localparam int              c_bcd_w    = 4 * DIGITS;
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_bin_sh;
  logic [c_bcd_w-1:0]   r_scratch;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [c_bcd_w-1:0]   r_bcd;

  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_scr_nxt;
  logic [WIDTH-1:0]     w_bin_nxt;

  // Each digit is corrected independently; no carry crosses digit boundaries.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ? r_scratch[4*d +: 4] + 4'd3
                                                           : r_scratch[4*d +: 4];
  end

  assign w_scr_nxt = {w_adj[c_bcd_w-2:0], r_bin_sh[WIDTH-1]};
  assign w_bin_nxt = {r_bin_sh[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bin_sh  <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_bin_sh  <= bus.bin;
            r_scratch <= '0;
            r_cnt     <= c_cnt_init;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_scr_nxt;
          r_bin_sh  <= w_bin_nxt;
          r_cnt     <= r_cnt - c_cnt_one;
          // Last bit shifted in: publish the finished digits in the same edge.
          if (r_cnt == c_cnt_one) begin
            r_bcd   <= w_scr_nxt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

endmodule

`default_nettype wire
